// File: rtl/display_frame_buffer.sv
// Double-buffered 4-bit pixel store feeding the display timing generator; banks swap on vsync fall.
// Optional fill engine (clear back bank to one colour) is built when FB_CLEAR_EN is defined.
module display_frame_buffer #(
    parameter int                 PIXELS      = 256000,
    parameter int                 ADDR_W      = 18,
    parameter int                 COLOR_W     = 4,
    parameter logic [COLOR_W-1:0] BLANK_COLOR = COLOR_W'(4)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    input  logic               swap_req,
    output logic               swap_pending,
    output logic               busy,
    input  logic               vsync,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COLOR_W-1:0] color,
    output logic               ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    logic               front_bank_reg;
    logic               swap_pending_reg;
    logic               ready_reg;
    logic               vsync_d_reg;
    logic               blank_reg;
    logic               sel_reg;
    logic               idle;
    logic               fill_start;
    logic [ADDR_W-1:0]  fill_addr;
    logic [COLOR_W-1:0] fill_data;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic               boundary;
    logic               do_swap;
    logic               back_bank;

    assign back_bank = ~front_bank_reg;

`ifdef FB_CLEAR_EN
    typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  fill_cnt_reg, fill_cnt_next;
    logic [COLOR_W-1:0] fill_color_reg, fill_color_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            fill_cnt_reg   <= '0;
            fill_color_reg <= '0;
        end else begin
            state_reg      <= state_next;
            fill_cnt_reg   <= fill_cnt_next;
            fill_color_reg <= fill_color_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        fill_cnt_next   = fill_cnt_reg;
        fill_color_next = fill_color_reg;
        case (state_reg)
            IDLE: begin
                if (clear_req) begin
                    state_next      = CLEAR;
                    fill_cnt_next   = '0;
                    fill_color_next = clear_color;
                end
            end
            CLEAR: begin
                // clear_req is deliberately not looked at here: requests during a fill are dropped
                fill_cnt_next = fill_cnt_reg + ADDR_W'(1);
                if (fill_cnt_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign idle       = (state_reg == IDLE);
    assign busy       = (state_reg == CLEAR);
    assign fill_start = idle && clear_req;
    assign fill_addr  = fill_cnt_reg;
    assign fill_data  = fill_color_reg;
`else
    logic unused_clear;

    assign unused_clear = ^{clear_req, clear_color};
    assign idle         = 1'b1;
    assign busy         = 1'b0;
    assign fill_start   = 1'b0;
    assign fill_addr    = '0;
    assign fill_data    = '0;
`endif

    assign wr_ready = reset_n && idle;

    // Single back-bank write port shared by the host and the fill engine; reset cancels both.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = wr_addr;
        mem_data = wr_color;
        if (reset_n) begin
            if (busy) begin
                mem_we   = 1'b1;
                mem_addr = fill_addr;
                mem_data = fill_data;
            end else if (wr_valid && (wr_addr <= LAST_ADDR)) begin
                mem_we = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : bank_g
            logic [COLOR_W-1:0] mem [0:PIXELS-1];
            logic [COLOR_W-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (mem_we && (back_bank == 1'(gi))) begin
                    mem[mem_addr] <= mem_data;
                end
                rd_q <= mem[rd_addr];
            end
        end
    endgenerate

    assign boundary = vsync_d_reg && !vsync;
    // A fill starting this cycle takes priority; the swap waits for a later boundary.
    assign do_swap  = boundary && (swap_pending_reg || swap_req) && idle && !fill_start;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            front_bank_reg   <= 1'b0;
            swap_pending_reg <= 1'b0;
            ready_reg        <= 1'b0;
            vsync_d_reg      <= 1'b0;
            blank_reg        <= 1'b1;
            sel_reg          <= 1'b0;
        end else begin
            vsync_d_reg <= vsync;
            if (do_swap) begin
                front_bank_reg   <= ~front_bank_reg;
                swap_pending_reg <= 1'b0;
                ready_reg        <= 1'b1;
            end else if (swap_req) begin
                swap_pending_reg <= 1'b1;
            end
            blank_reg <= !ready_reg || (rd_addr > LAST_ADDR);
            sel_reg   <= front_bank_reg;
        end
    end

    // Raw RAM data stays unreset so both banks map onto block RAM; blanking is applied after.
    assign color        = blank_reg ? BLANK_COLOR : (sel_reg ? bank_g[1].rd_q : bank_g[0].rd_q);
    assign swap_pending = swap_pending_reg;
    assign ready        = ready_reg;

endmodule

// File: tb/tb_display_frame_buffer.sv
// Scoreboard bench for display_frame_buffer; fill-engine scenarios run only when FB_CLEAR_EN is defined.
module tb_display_frame_buffer;

    localparam int S_COLOR   = 0;
    localparam int S_READY   = 1;
    localparam int S_WRREADY = 2;
    localparam int S_BUSY    = 3;
    localparam int S_PENDING = 4;

    typedef struct {
        int    due;
        int    sig;
        int    exp;
        string name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [17:0] wr_addr;
    logic [3:0]  wr_color;
    logic        clear_req;
    logic [3:0]  clear_color;
    logic        swap_req;
    logic        swap_pending;
    logic        busy;
    logic        vsync;
    logic [17:0] rd_addr;
    logic [3:0]  color;
    logic        ready;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    display_frame_buffer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_color     (wr_color),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .busy         (busy),
        .vsync        (vsync),
        .rd_addr      (rd_addr),
        .color        (color),
        .ready        (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(input int sig);
        case (sig)
            S_COLOR:   return int'(color);
            S_READY:   return int'(ready);
            S_WRREADY: return int'(wr_ready);
            S_BUSY:    return int'(busy);
            default:   return int'(swap_pending);
        endcase
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endfunction

    // Monitor: compare every expectation that falls due at this cycle's mid-point.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].name, sample(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int sig, input int exp, input string name);
        sb.push_back('{cyc, sig, exp, name});
    endtask

    task automatic expect_next(input int sig, input int exp, input string name);
        sb.push_back('{cyc + 1, sig, exp, name});
    endtask

    task automatic wr(input logic [17:0] a, input logic [3:0] c);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_color = c;
        expect_now(S_WRREADY, 1, "wr_accept");
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [17:0] a, input int exp, input string name);
        rd_addr = a;
        expect_next(S_COLOR, exp, name);
        tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_color    = '0;
        clear_req   = 1'b0;
        clear_color = '0;
        swap_req    = 1'b0;
        vsync       = 1'b1;
        rd_addr     = '0;
        repeat (3) tick();

        expect_now(S_READY, 0, "rst_ready");
        expect_now(S_BUSY, 0, "rst_busy");
        expect_now(S_PENDING, 0, "rst_pending");
        expect_now(S_COLOR, 4, "rst_color");
        expect_now(S_WRREADY, 0, "rst_wr_ready");
        tick();
        reset_n = 1'b1;
        expect_now(S_WRREADY, 1, "wr_ready_after_release");

        for (int a = 0; a < 6; a++) begin
            expect_next(S_READY, 0, "unpublished_ready");
            rd(18'(a), 4, "unpublished_blank");
        end

        wr(18'd0, 4'd1);
        wr(18'd1, 4'd2);
        wr(18'd255999, 4'd3);
        wr(18'd256000, 4'd2);

        swap_req = 1'b1;
        expect_next(S_PENDING, 1, "swap_pending_set");
        tick();
        swap_req = 1'b0;
        vsync    = 1'b0;
        expect_now(S_PENDING, 1, "pending_before_fall");
        expect_next(S_PENDING, 0, "pending_clear_at_fall");
        expect_next(S_READY, 1, "ready_at_fall");
        tick();
        vsync = 1'b1;
        rd(18'd0, 1, "rd_addr0");
        rd(18'd1, 2, "rd_addr1");
        rd(18'd255999, 3, "rd_addr_last");
        rd(18'd256000, 4, "rd_out_of_range");

        // Back bank is now bank 0; after reset front returns to 0 so the next swap shows bank 1.
        wr(18'd0, 4'd7);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        expect_now(S_BUSY, 0, "rst2_busy");
        expect_now(S_READY, 0, "rst2_ready");
        expect_now(S_PENDING, 0, "rst2_pending");
        expect_now(S_COLOR, 4, "rst2_color");
        expect_now(S_WRREADY, 1, "rst2_wr_ready");
        rd(18'd0, 4, "rst2_blank_read");

        swap_req = 1'b1;
        vsync    = 1'b0;
        expect_next(S_PENDING, 0, "same_cycle_swap_pending");
        expect_next(S_READY, 1, "same_cycle_swap_ready");
        tick();
        swap_req = 1'b0;
        vsync    = 1'b1;
        rd(18'd0, 1, "front_after_reset_addr0");
        rd(18'd1, 2, "front_after_reset_addr1");

        swap_req = 1'b1;
        expect_next(S_PENDING, 1, "swap2_pending_set");
        tick();
        swap_req = 1'b0;
        repeat (2) tick();
        expect_now(S_PENDING, 1, "swap2_pending_held");
        vsync = 1'b0;
        expect_next(S_PENDING, 0, "swap2_pending_clear");
        tick();
        vsync = 1'b1;
        rd(18'd0, 7, "swap2_addr0");

`ifdef FB_CLEAR_EN
        begin
            int n;
            int bad;
            clear_req   = 1'b1;
            clear_color = 4'd0;
            expect_next(S_BUSY, 1, "fill_busy_start");
            expect_next(S_WRREADY, 0, "fill_wr_ready_start");
            tick();
            clear_req = 1'b0;
            n   = 0;
            bad = 0;
            while (busy && n < 300000) begin
                if (wr_ready) bad++;
                swap_req    = (n == 500);
                vsync       = (n != 1000);
                clear_req   = (n == 2000);
                clear_color = 4'd5;
                if (n == 1001) begin
                    expect_now(S_PENDING, 1, "fill_swap_deferred");
                    expect_now(S_BUSY, 1, "fill_busy_at_fall");
                end
                n++;
                tick();
            end
            swap_req  = 1'b0;
            clear_req = 1'b0;
            vsync     = 1'b1;
            chk("fill_busy_cycles", n, 256000);
            chk("fill_wr_ready_low", bad, 0);
            expect_now(S_PENDING, 1, "pending_after_fill");
            tick();
            vsync = 1'b0;
            expect_next(S_PENDING, 0, "swap_after_fill");
            expect_next(S_BUSY, 0, "fill_req_not_queued");
            tick();
            vsync = 1'b1;
            rd(18'd0, 0, "cleared_addr0");
            rd(18'd128000, 0, "cleared_addr_mid");
            rd(18'd255999, 0, "cleared_addr_last");

            clear_req   = 1'b1;
            clear_color = 4'd9;
            tick();
            clear_req = 1'b0;
            repeat (499) tick();
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            expect_now(S_BUSY, 0, "midfill_rst_busy");
            expect_now(S_READY, 0, "midfill_rst_ready");
            expect_now(S_PENDING, 0, "midfill_rst_pending");
            expect_now(S_COLOR, 4, "midfill_rst_color");
            tick();
        end
`endif

        repeat (3) tick();
        for (int i = 0; i < sb.size(); i++) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: never sampled, expected %0d", sb[i].name, sb[i].exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/display_frame_buffer.md
Name: display_frame_buffer

Overview:
Double-buffered 4-bit pixel store sitting directly upstream of the display timing generator.
- Host/graphics side writes pixels into the back bank.
- Display side reads the front bank through an 18-bit read address and receives a 4-bit colour code.
- Banks swap only at a frame boundary, so the panel never shows a partially drawn frame.
- Includes a fill engine that clears the back bank to one colour.

Parameters:
PIXELS, 256000, pixels per bank (640x400 active area)
ADDR_W, 18, width of read/write pixel addresses
COLOR_W, 4, bits per pixel colour code
BLANK_COLOR, 4, colour code driven on color while no frame has been published (downstream decodes as black)

Ports:
clk  in  1  pixel-domain clock; same clock as the display timing generator
reset_n  in  1  reset, synchronous, active-low
wr_valid  in  1  host pixel write request
wr_ready  out  1  write accepted when wr_valid & wr_ready on a rising clk edge
wr_addr  in  ADDR_W  back-bank pixel address, row-major, 0..PIXELS-1
wr_color  in  COLOR_W  pixel colour code
clear_req  in  1  single-cycle pulse: fill back bank with clear_color
clear_color  in  COLOR_W  fill colour, sampled on the cycle clear_req is accepted
swap_req  in  1  single-cycle pulse: publish back bank at next frame boundary
swap_pending  out  1  swap requested, not yet executed
busy  out  1  fill engine running
vsync  in  1  vertical sync from display timing generator (low = sync pulse)
rd_addr  in  ADDR_W  front-bank read address from display timing generator
color  out  COLOR_W  front-bank pixel at rd_addr, 1-cycle latency
ready  out  1  high once at least one frame has been published

Behaviour:
- Storage: two banks of PIXELS x COLOR_W; bank select bit front_bank. Writes and fills target the back bank (!front_bank); reads use front_bank.
- Reset (reset_n low at a clk edge):
  - front_bank=0, swap_pending=0, busy=0, ready=0, wr_ready=0, color=BLANK_COLOR.
  - FSM returns to IDLE; vsync_d=0. Memory contents are not cleared.
- Read path:
  - color registered; color(t+1) = front_bank[rd_addr(t)] when ready=1, else BLANK_COLOR.
  - rd_addr >= PIXELS returns BLANK_COLOR.
  - Reads never stall and are unaffected by writes, because the banks are disjoint.
- Write path:
  - wr_ready=1 only in IDLE, including the first cycle after reset release.
  - An accepted write lands in the back bank on that edge.
  - wr_addr >= PIXELS: accepted and dropped, with no side effect.
- Fill FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req=1. Latches clear_color; fill counter=0; busy=1 and wr_ready=0 from the next cycle.
  - CLEAR: writes the latched colour to counter address, one pixel per cycle; counter increments.
  - CLEAR -> IDLE after address PIXELS-1 is written (exactly PIXELS cycles in CLEAR). busy and wr_ready update on the same edge.
  - clear_req during CLEAR: ignored, not queued.
  - wr_valid and clear_req in the same IDLE cycle: the write is performed, then the fill starts and overwrites it.
- Swap:
  - Frame boundary = falling edge of vsync: vsync_d=1 and vsync=0, where vsync_d is vsync registered.
  - swap_req sets swap_pending; swap_req while already pending has no additional effect.
  - At a boundary with swap_pending=1 and FSM in IDLE (and no clear_req that cycle):
    - front_bank toggles, swap_pending clears, ready sets to 1 (sticky until reset).
  - At a boundary with busy=1: swap is deferred to the first boundary after the fill completes; swap_pending stays 1.
  - swap_req in the same cycle as a boundary takes effect at that boundary.
  - A write accepted on the swap edge goes to the old back bank, which becomes the new front bank. Host must not write while swap_pending=1; not checked in RTL.
- Reset mid-fill: fill aborts immediately; partially filled bank contents persist.
- Counter widths: fill counter ADDR_W bits; PIXELS-1 must fit in ADDR_W.

Optional Feature:
FB_CLEAR_EN
- Defined: fill engine and CLEAR state are present as above.
- Undefined: no fill engine; clear_req and clear_color are ignored; busy tied 0; wr_ready is 1 whenever out of reset; swap executes at the first boundary with swap_pending=1.

Test Plan:
- Reset release, no swap: rd_addr sweeps 0..5 -> color=4 every cycle, ready=0, wr_ready=1 the first cycle after release.
- Write addr 0=1, addr 1=2, addr 255999=3; swap_req; vsync 1->0 -> swap_pending drops on that edge, ready=1; rd_addr 0,1,255999 return 1,2,3 one cycle later.
- Write addr 256000 colour 2 -> wr_ready=1 (accepted), no bank change; after swap, rd_addr 256000 reads 4.
- (FB_CLEAR_EN) clear_req with clear_color=0 -> busy=1 for 256000 cycles, wr_ready=0 throughout; after swap, addrs 0, 128000, 255999 read 0.
- (FB_CLEAR_EN) clear_req, then swap_req, then a vsync fall at cycle 1000 -> no swap, swap_pending=1; swap occurs at the first vsync fall after busy drops.
- Reset asserted mid-fill at cycle 500 -> busy=0, ready=0, front_bank=0, color=4 the next cycle.
